// File: rtl/if_unit_ras.sv
// rtl/if_unit_ras.sv - instruction fetch unit with return-address stack (optional IF_REL_BRANCH_EN: PC-relative targets)
module if_unit_ras #(
  parameter int PCW       = 8,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0,
  parameter int PC_INC    = 1
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           Halt,
  input  logic           branch,
  input  logic           call,
  input  logic           ret,
  input  logic [PCW-1:0] branch_adr,
  output logic [PCW-1:0] PC,
  output logic           ras_empty,
  output logic           ras_full,
  output logic           ras_err,
  output logic           halted
);

  localparam int PTRW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNTW = PTRW + 1;
  localparam logic [PCW-1:0]  INC     = PCW'(PC_INC);
  localparam logic [PCW-1:0]  RST_PC  = PCW'(RESET_PC);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(RAS_DEPTH);

  logic [PCW-1:0]  pc_q, pc_n;
  logic [PTRW-1:0] ptr_q, ptr_n, ptr_dec;
  logic [CNTW-1:0] cnt_q, cnt_n;
  logic            err_q, err_n;
  logic            halted_q;
  logic            push_en;
  logic [PCW-1:0]  seq_pc;
  logic [PCW-1:0]  target;
  logic [PCW-1:0]  ras [RAS_DEPTH];

  // ptr_q points at the next free slot; when full it points at the oldest
  // entry, so a push on overflow overwrites the oldest return address.
  assign ptr_dec = ptr_q - PTRW'(1);
  assign seq_pc  = pc_q + INC;

`ifdef IF_REL_BRANCH_EN
  assign target = pc_q + branch_adr;
`else
  assign target = branch_adr;
`endif

  // Next-state selection: Halt > ret > call > branch > sequential
  always_comb begin
    pc_n    = pc_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    push_en = 1'b0;
    if (Halt) begin
      pc_n = pc_q;
    end else if (ret) begin
      if (cnt_q != '0) begin
        pc_n  = ras[ptr_dec];
        ptr_n = ptr_dec;
        cnt_n = cnt_q - CNTW'(1);
      end else begin
        pc_n  = seq_pc;
        err_n = 1'b1;
      end
    end else if (call) begin
      push_en = 1'b1;
      pc_n    = target;
      ptr_n   = ptr_q + PTRW'(1);
      if (cnt_q == CNT_MAX) begin
        err_n = 1'b1;
      end else begin
        cnt_n = cnt_q + CNTW'(1);
      end
    end else if (branch) begin
      pc_n = target;
    end else begin
      pc_n = seq_pc;
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q     <= RST_PC;
      ptr_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_n;
      ptr_q    <= ptr_n;
      cnt_q    <= cnt_n;
      err_q    <= err_n;
      halted_q <= Halt;
    end
  end

  // Return-address storage; push writes the sequential successor of the caller
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras[i] <= '0;
      end
    end else if (push_en) begin
      ras[ptr_q] <= seq_pc;
    end
  end

  assign PC        = pc_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);
  assign ras_err   = err_q;
  assign halted    = halted_q;

endmodule

// File: doc/if_unit_ras.md
Name: if_unit_ras

Overview:
- Parametrised instruction-fetch unit: successor to the single-PC fetch block. Holds the program counter and drives it to instruction memory.
- Adds to plain increment/branch/halt:
  - call and return operations, backed by a return-address stack (RAS) of configurable depth;
  - a configurable reset vector and increment step;
  - RAS status and error flags for the controller.

Parameters:
- PCW, 8, PC and address width in bits.
- RAS_DEPTH, 4, number of RAS entries (≥2, power of two).
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 1, sequential increment per cycle.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Halt  input  1  freeze PC and RAS while high.
- branch  input  1  load branch target this cycle.
- call  input  1  push return address, then jump to target.
- ret  input  1  pop RAS into PC.
- branch_adr  input  PCW  branch/call target (signed).
- PC  output  PCW  current fetch address.
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_err  output  1  sticky overflow/underflow flag.
- halted  output  1  registered copy of Halt.

Behaviour:
- Reset asserted, at any time including mid-operation, with no clock edge required:
  - PC=RESET_PC, RAS count=0, RAS pointer=0, ras_err=0, halted=0.
  - ras_empty=1, ras_full=0.
- Single register stage. All updates occur on rising CLK and are visible the next cycle. Zero combinational path from inputs to PC.
- Control priority per cycle: Halt > ret > call > branch > sequential.
- Halt=1:
  - PC, RAS and ras_err hold.
  - halted=1 the cycle after.
  - All other controls are ignored.
- ret with RAS non-empty: PC <= top entry; count decrements; pointer moves back.
- ret with RAS empty (underflow): PC <= PC+PC_INC; ras_err <= 1; count stays 0.
- call with RAS not full: push (PC+PC_INC); PC <= target; count increments.
- call with RAS full (overflow):
  - Circular overwrite of the oldest entry; push proceeds; PC <= target.
  - Count stays RAS_DEPTH; ras_err <= 1.
- branch: PC <= target; RAS unchanged.
- Otherwise: PC <= PC+PC_INC.
- Arithmetic:
  - All PC arithmetic is modulo 2^PCW; wrap-around is legal and silent (e.g. PCW=8, PC=8'hFF, inc 1 → 8'h00).
  - Return address is computed with the same wrap.
- Flags:
  - ras_err is sticky; only Reset clears it.
  - ras_empty and ras_full are decoded from the registered count (combinational from state only).
- Simultaneous call+ret: ret wins; call is dropped with no push.
- Simultaneous call+branch: treated as call.

Optional Feature:
- Macro: IF_REL_BRANCH_EN.
- Defined: target = PC + sign-extended branch_adr, computed mod 2^PCW. Applies to both branch and call.
- Undefined: target = branch_adr (absolute).
- ret and sequential behaviour are identical in both builds.

Test Plan:
- Reset then free-run: Reset pulse, 12 cycles, no controls → PC sequence 0,1,…,12; ras_empty=1; ras_err=0.
- Absolute branch at PC=8'h0B: branch=1, branch_adr=8'h40 for one cycle → PC=8'h40 next cycle, then 8'h41, 8'h42. Halt=1 for 3 cycles → PC held at its value; halted=1 from the cycle after assertion.
- Call/return round trip:
  - At PC=8'h05: call, branch_adr=8'h80 → PC=8'h80, RAS count=1.
  - 3 idle cycles → PC=8'h83.
  - ret → PC=8'h06, ras_empty=1.
- Overflow (RAS_DEPTH=4): 5 consecutive calls from PCs p0..p4 → ras_full=1, ras_err=1. Then 4 rets return p4+1, p3+1, p2+1, p1+1; next ret underflows → PC increments, ras_err stays 1.
- Wrap, mid-op reset and relative mode:
  - PC=8'hFE, 3 idle cycles → 8'hFF, 8'h00, 8'h01.
  - Assert Reset asynchronously between clock edges with RAS count=2 → PC=RESET_PC immediately; count=0.
  - With IF_REL_BRANCH_EN, PC=8'h10, branch_adr=8'hF8 (−8) → PC=8'h08.
